// File: rtl/mb_word_seq_if.sv
// MB sequencer handshake bundle: requests, memory handshakes and MB array controls.
// master = EBOX/memory side, slave = the word sequencer.
interface mb_word_seq_if;
    logic       RD_REQ;
    logic       WB_REQ;
    logic       ST_REQ;
    logic [1:0] START_WD;
    logic [3:0] WD_MASK;
    logic       MEM_DATA_VALID;
    logic       MEM_ACK;
    logic       NXM;
    logic [3:0] MB_LOAD;
    logic [1:0] MB_SEL;
    logic [2:0] MB_IN_SEL;
    logic       MEM_WR_RQ;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    modport master (
        output RD_REQ, WB_REQ, ST_REQ, START_WD, WD_MASK, MEM_DATA_VALID, MEM_ACK, NXM,
        input  MB_LOAD, MB_SEL, MB_IN_SEL, MEM_WR_RQ, BUSY, DONE, ERR
    );

    modport slave (
        input  RD_REQ, WB_REQ, ST_REQ, START_WD, WD_MASK, MEM_DATA_VALID, MEM_ACK, NXM,
        output MB_LOAD, MB_SEL, MB_IN_SEL, MEM_WR_RQ, BUSY, DONE, ERR
    );
endinterface

// File: rtl/mb_word_seq.sv
// MB word sequencer: quadword fill, masked writeback and single-word store; requests taken in IDLE only.
// Loads/write requests respond in the same cycle; FILL/WB wait on VALID/ACK under a TMO_LIMIT watchdog.
module mb_word_seq #(
    parameter logic [7:0] TMO_LIMIT = 8'd255
) (
    input  logic         clk,
    input  logic         RESET,
    mb_word_seq_if.slave mb
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WB    = 3'd2,
        S_STORE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] wd_q, wd_d;
    logic [1:0] start_q, start_d;
    logic [3:0] rem_q, rem_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
    logic [1:0] sel_q, sel_d;

    logic [1:0] wb_cur;
    logic       wb_any;
    logic       wb_last;
    logic       tmo_hit;
    logic       req_any;

    // First still-masked word at or after WD in wrap order; the smallest offset wins.
    always_comb begin
        logic [1:0] idx;
        idx    = 2'd0;
        wb_cur = wd_q;
        wb_any = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = wd_q + 2'(k);
            if (rem_q[idx]) begin
                wb_cur = idx;
                wb_any = 1'b1;
            end
        end
    end

    assign wb_last = ((rem_q & ~(4'b0001 << wb_cur)) == 4'b0000);
    assign tmo_hit = ((tmo_q + 8'd1) == TMO_LIMIT);
    assign req_any = mb.WB_REQ | mb.RD_REQ | mb.ST_REQ;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mb.WB_REQ) begin
                    state_d = S_WB;
                end else if (mb.RD_REQ) begin
                    state_d = S_FILL;
                end else if (mb.ST_REQ) begin
                    state_d = S_STORE;
                end
            end
            S_FILL: begin
                if (mb.NXM) begin
                    state_d = S_FIN;
                end else if (mb.MEM_DATA_VALID) begin
                    if (cnt_q == 3'd3) begin
                        state_d = S_FIN;
                    end
                end else if (tmo_hit) begin
                    state_d = S_FIN;
                end
            end
            S_WB: begin
                if (mb.NXM || !wb_any) begin
                    state_d = S_FIN;
                end else if (mb.MEM_ACK) begin
                    if (wb_last) begin
                        state_d = S_FIN;
                    end
                end else if (tmo_hit) begin
                    state_d = S_FIN;
                end
            end
            S_STORE: state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NXM takes precedence over a coincident VALID/ACK: the word is neither counted nor retired.
    always_comb begin
        wd_d    = wd_q;
        start_d = start_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    wd_d    = mb.START_WD;
                    start_d = mb.START_WD;
                    rem_d   = mb.WD_MASK;
                    cnt_d   = 3'd0;
                    tmo_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end
            S_FILL: begin
                if (mb.NXM) begin
                    err_d = 1'b1;
                end else if (mb.MEM_DATA_VALID) begin
                    wd_d  = wd_q + 2'd1;
                    cnt_d = cnt_q + 3'd1;
                    tmo_d = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    err_d = tmo_hit;
                end
            end
            S_WB: begin
                if (wb_any) begin
                    wd_d  = wb_cur;
                    sel_d = wb_cur;
                    if (mb.NXM) begin
                        err_d = 1'b1;
                    end else if (mb.MEM_ACK) begin
                        rem_d[wb_cur] = 1'b0;
                        tmo_d         = 8'd0;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                        err_d = tmo_hit;
                    end
                end else if (mb.NXM) begin
                    err_d = 1'b1;
                end
            end
            S_FIN:   err_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            wd_q    <= 2'd0;
            start_q <= 2'd0;
            rem_q   <= 4'd0;
            cnt_q   <= 3'd0;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
            sel_q   <= 2'd0;
        end else begin
            wd_q    <= wd_d;
            start_q <= start_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        mb.MB_LOAD   = 4'b0000;
        mb.MB_SEL    = sel_q;
        mb.MB_IN_SEL = 3'b000;
        mb.MEM_WR_RQ = 1'b0;
        mb.BUSY      = (state_q != S_IDLE);
        mb.DONE      = (state_q == S_FIN);
        mb.ERR       = (state_q == S_FIN) && err_q;
        case (state_q)
            S_FILL: begin
                mb.MB_IN_SEL = 3'b100;
                if (mb.MEM_DATA_VALID && !mb.NXM) begin
                    mb.MB_LOAD = 4'b0001 << wd_q;
                end
            end
            S_WB: begin
                if (wb_any) begin
                    mb.MB_SEL    = wb_cur;
                    mb.MEM_WR_RQ = !mb.NXM;
                end
            end
            S_STORE: begin
                mb.MB_IN_SEL = 3'b010;
                mb.MB_LOAD   = 4'b0001 << start_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mb_word_seq.sv
// Bench for mb_word_seq: directed scenarios plus random transactions, every cycle compared
// against a word-queue model of the expected loads, writeback order, watchdog and abort rules.
module tb_mb_word_seq;
    localparam int TMO     = 255;
    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_WB    = 2;
    localparam int M_STORE = 3;
    localparam int M_FIN   = 4;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    mb_word_seq_if mb ();
    mb_word_seq #(.TMO_LIMIT(8'd255)) dut (.clk(clk), .RESET(RESET), .mb(mb));

    int total = 0;
    int bad   = 0;

    int         m_state = M_IDLE;
    logic [1:0] m_q[$];
    logic [1:0] m_st  = 2'd0;
    logic [1:0] m_sel = 2'd0;
    logic       m_err = 1'b0;
    int         m_idle = 0;

    int         n_load = 0;
    int         n_wr   = 0;
    int         n_done = 0;
    int         n_err  = 0;
    logic [3:0] obs_loads[$];
    logic [1:0] obs_sel[$];
    string      phase = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs mid-cycle with the model, then advance the model.
    task automatic step(input logic rst, input logic [2:0] req, input logic v, input logic a, input logic n);
        logic [3:0] e_load;
        logic [1:0] e_sel;
        logic [2:0] e_in;
        logic       e_wr;
        logic [1:0] w;
        RESET = rst;
        {mb.WB_REQ, mb.RD_REQ, mb.ST_REQ} = req;
        mb.MEM_DATA_VALID = v;
        mb.MEM_ACK = a;
        mb.NXM = n;
        e_load = 4'b0000;
        e_sel  = m_sel;
        e_in   = 3'b000;
        e_wr   = 1'b0;
        if (m_state == M_FILL) begin
            e_in = 3'b100;
            if (v && !n) e_load = 4'b0001 << m_q[0];
        end else if (m_state == M_WB && m_q.size() > 0) begin
            e_sel = m_q[0];
            e_wr  = !n;
        end else if (m_state == M_STORE) begin
            e_in   = 3'b010;
            e_load = 4'b0001 << m_st;
        end
        @(negedge clk);
        chk("MB_LOAD", 32'(mb.MB_LOAD), 32'(e_load));
        chk("MB_SEL", 32'(mb.MB_SEL), 32'(e_sel));
        chk("MB_IN_SEL", 32'(mb.MB_IN_SEL), 32'(e_in));
        chk("MEM_WR_RQ", 32'(mb.MEM_WR_RQ), 32'(e_wr));
        chk("BUSY", 32'(mb.BUSY), 32'(m_state != M_IDLE));
        chk("DONE", 32'(mb.DONE), 32'(m_state == M_FIN));
        chk("ERR", 32'(mb.ERR), 32'((m_state == M_FIN) && m_err));
        if (mb.MB_LOAD !== 4'b0000) begin
            n_load++;
            obs_loads.push_back(mb.MB_LOAD);
        end
        if (mb.MEM_WR_RQ === 1'b1) begin
            n_wr++;
            obs_sel.push_back(mb.MB_SEL);
        end
        if (mb.DONE === 1'b1) n_done++;
        if (mb.ERR === 1'b1) n_err++;
        if (rst) begin
            m_state = M_IDLE;
            m_sel   = 2'd0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (req != 3'b000) begin
                        m_err  = 1'b0;
                        m_idle = 0;
                        m_q.delete();
                    end
                    if (req[2]) begin
                        m_state = M_WB;
                        for (int k = 0; k < 4; k++) begin
                            w = mb.START_WD + 2'(k);
                            if (mb.WD_MASK[w]) m_q.push_back(w);
                        end
                    end else if (req[1]) begin
                        m_state = M_FILL;
                        for (int k = 0; k < 4; k++) begin
                            w = mb.START_WD + 2'(k);
                            m_q.push_back(w);
                        end
                    end else if (req[0]) begin
                        m_state = M_STORE;
                        m_st    = mb.START_WD;
                    end
                end
                M_FILL: begin
                    if (n) begin
                        m_err = 1'b1;
                        m_state = M_FIN;
                    end else if (v) begin
                        void'(m_q.pop_front());
                        m_idle = 0;
                        if (m_q.size() == 0) m_state = M_FIN;
                    end else begin
                        m_idle++;
                        if (m_idle >= TMO) begin
                            m_err = 1'b1;
                            m_state = M_FIN;
                        end
                    end
                end
                M_WB: begin
                    if (m_q.size() > 0) m_sel = m_q[0];
                    if (n) begin
                        m_err = 1'b1;
                        m_state = M_FIN;
                    end else if (m_q.size() == 0) begin
                        m_state = M_FIN;
                    end else if (a) begin
                        void'(m_q.pop_front());
                        m_idle = 0;
                        if (m_q.size() == 0) m_state = M_FIN;
                    end else begin
                        m_idle++;
                        if (m_idle >= TMO) begin
                            m_err = 1'b1;
                            m_state = M_FIN;
                        end
                    end
                end
                M_STORE: m_state = M_FIN;
                default: m_state = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while (m_state != M_IDLE && g < 600) begin
            step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
            g++;
        end
    endtask

    initial begin
        int d0, l0, w0, e0, cyc, g, vp, np;
        logic [2:0] rq;
        bit vpat[8];
        bit apat[4];
        logic [3:0] exp_fill[4];
        logic [1:0] exp_sel[4];

        RESET = 1'b1;
        {mb.WB_REQ, mb.RD_REQ, mb.ST_REQ} = 3'b000;
        mb.START_WD = 2'd0;
        mb.WD_MASK = 4'd0;
        mb.MEM_DATA_VALID = 1'b0;
        mb.MEM_ACK = 1'b0;
        mb.NXM = 1'b0;
        @(posedge clk);
        #1;

        phase = "reset";
        step(1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        phase = "fill";
        mb.START_WD = 2'd2;
        l0 = n_load; d0 = n_done; e0 = n_err;
        obs_loads.delete();
        vpat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_fill = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 3'b000, vpat[i], 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("loads", 32'(n_load - l0), 32'd4);
        for (int i = 0; i < 4; i++) chk("load_order", 32'(obs_loads[i]), 32'(exp_fill[i]));
        chk("done", 32'(n_done - d0), 32'd1);
        chk("err", 32'(n_err - e0), 32'd0);

        phase = "wb";
        mb.START_WD = 2'd3;
        mb.WD_MASK = 4'b0101;
        l0 = n_load; d0 = n_done; w0 = n_wr;
        obs_sel.delete();
        apat = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_sel = '{2'd0, 2'd0, 2'd2, 2'd2};
        step(1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b0, apat[i], 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("wr_cycles", 32'(n_wr - w0), 32'd4);
        for (int i = 0; i < 4; i++) chk("sel_order", 32'(obs_sel[i]), 32'(exp_sel[i]));
        chk("loads", 32'(n_load - l0), 32'd0);
        chk("done", 32'(n_done - d0), 32'd1);

        phase = "wb0";
        mb.WD_MASK = 4'b0000;
        d0 = n_done; w0 = n_wr;
        step(1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("done", 32'(n_done - d0), 32'd1);
        chk("wr_cycles", 32'(n_wr - w0), 32'd0);

        phase = "arb";
        mb.START_WD = 2'd0;
        mb.WD_MASK = 4'b0011;
        l0 = n_load; d0 = n_done; w0 = n_wr;
        step(1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
        g = 0;
        while (m_state != M_IDLE && g < 50) begin
            step(1'b0, 3'b111, 1'b1, 1'b1, 1'b0);
            g++;
        end
        chk("first_is_wb_loads", 32'(n_load - l0), 32'd0);
        chk("first_is_wb_wr", 32'(n_wr - w0), 32'd2);
        chk("done", 32'(n_done - d0), 32'd1);
        step(1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
        drain();
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("done_again", 32'(n_done - d0), 32'd2);

        phase = "nxm";
        mb.START_WD = 2'd0;
        l0 = n_load; d0 = n_done; e0 = n_err;
        step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("loads", 32'(n_load - l0), 32'd1);
        chk("done", 32'(n_done - d0), 32'd1);
        chk("err", 32'(n_err - e0), 32'd1);

        phase = "tmo_fill";
        d0 = n_done; e0 = n_err; cyc = 0;
        step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        while (n_done == d0 && cyc < 400) begin
            step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
            cyc++;
        end
        drain();
        chk("cycles_to_done", 32'(cyc), 32'd256);
        chk("err", 32'(n_err - e0), 32'd1);

        phase = "tmo_wb";
        mb.WD_MASK = 4'b1000;
        d0 = n_done; e0 = n_err; cyc = 0;
        step(1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        while (n_done == d0 && cyc < 400) begin
            step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
            cyc++;
        end
        drain();
        chk("cycles_to_done", 32'(cyc), 32'd256);
        chk("err", 32'(n_err - e0), 32'd1);

        phase = "store";
        mb.START_WD = 2'd1;
        l0 = n_load; d0 = n_done; e0 = n_err;
        obs_loads.delete();
        step(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("loads", 32'(n_load - l0), 32'd1);
        chk("load_word", 32'(obs_loads[0]), 32'h2);
        chk("done", 32'(n_done - d0), 32'd1);
        chk("err", 32'(n_err - e0), 32'd0);

        phase = "rst_mid";
        mb.START_WD = 2'd0;
        d0 = n_done;
        step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("no_done", 32'(n_done - d0), 32'd0);

        phase = "rand";
        for (int t = 0; t < 40; t++) begin
            rq = 3'($urandom_range(7));
            mb.START_WD = 2'($urandom_range(3));
            mb.WD_MASK = 4'($urandom_range(15));
            vp = $urandom_range(100, 30);
            np = $urandom_range(40);
            d0 = n_done; e0 = n_err;
            step(1'b0, rq, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            g = 0;
            while (m_state != M_IDLE && g < 600) begin
                step(1'b0, 3'($urandom_range(7)),
                     1'($urandom_range(99) < vp), 1'($urandom_range(99) < vp),
                     1'($urandom_range(999) < np));
                g++;
            end
            chk("txn_done", 32'(n_done - d0), 32'(rq != 3'b000));
            chk("txn_err", 32'(n_err - e0), 32'((rq != 3'b000) && m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
